// File: rtl/clkctrl_pkg.sv
// -----------------------------------------------------------------------------
// clkctrl_pkg
//   Shared definitions for the clock-select sequencer family.
//   - clksel_state_e : encoding of the four sequencer states
//   - *_DEF          : default values for the sequencer parameters
//   - cnt_width()    : bit width needed for a down/up counter reaching max_val
// -----------------------------------------------------------------------------
package clkctrl_pkg;

    // Settled states are LS/HS; TO_* are the in-flight switch states.
    typedef enum logic [1:0] {
        CLKSEL_LS    = 2'd0,
        CLKSEL_TO_HS = 2'd1,
        CLKSEL_HS    = 2'd2,
        CLKSEL_TO_LS = 2'd3
    } clksel_state_e;

    localparam int SYNC_STAGES_DEF    = 2;
    localparam int DWELL_CYCLES_DEF   = 16;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    // Width of a counter that must hold values 0..max_val (never below 1 bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : clkctrl_pkg

// File: rtl/clksel_seq_if.sv
// -----------------------------------------------------------------------------
// clksel_seq_if
//   Bundles the request, clock-switch feedback and status signals of the
//   clock-select sequencer.
//
//   Request handshake: req_valid is a single-cycle strobe with req_fast as its
//   payload. There is no ready signal; every strobe is consumed in the cycle
//   it is presented -- acted on, latched as the pending request (last one
//   wins), or discarded when it names the clock already selected. busy tells
//   the requester that a strobe will not take effect immediately.
//
//   Signals:
//     req_valid       request strobe
//     req_fast        requested clock (1 = HS, 0 = LS)
//     hsclk_selected  asynchronous feedback from the clock switch
//     lsclk_selected  asynchronous feedback from the clock switch
//     hsclk_sel       registered select to the clock switch
//     busy            switch in flight, dwell running or request pending
//     switch_done     one-cycle pulse on confirmed switch
//     switch_err      sticky timeout flag
//
//   Modports:
//     master : requester plus clock-switch side (drives request and feedback)
//     slave  : the sequencer
// -----------------------------------------------------------------------------
interface clksel_seq_if;

    logic req_valid;
    logic req_fast;
    logic hsclk_selected;
    logic lsclk_selected;
    logic hsclk_sel;
    logic busy;
    logic switch_done;
    logic switch_err;

    modport master (
        output req_valid,
        output req_fast,
        output hsclk_selected,
        output lsclk_selected,
        input  hsclk_sel,
        input  busy,
        input  switch_done,
        input  switch_err
    );

    modport slave (
        input  req_valid,
        input  req_fast,
        input  hsclk_selected,
        input  lsclk_selected,
        output hsclk_sel,
        output busy,
        output switch_done,
        output switch_err
    );

endinterface : clksel_seq_if

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//   Plain flop-chain synchroniser for one asynchronous level signal.
//
//   Parameters:
//     STAGES  number of flops in the chain (>= 1)
//   Ports:
//     clk  in   destination clock
//     rst  in   synchronous active-high reset, clears every stage
//     d    in   asynchronous input
//     q    out  synchronised output (last stage)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 1) begin : g_bad_stages
        $error("sync_ff: STAGES must be at least 1");
    end

    logic [STAGES-1:0] chain;

    // Shift form works for any depth including a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= (chain << 1) | STAGES'(d);
        end
    end

    assign q = chain[STAGES-1];

endmodule : sync_ff

// File: rtl/clksel_seq.sv
// -----------------------------------------------------------------------------
// clksel_seq
//   Sequencer for a glitch-free HS/LS clock switch. Accepts clock requests,
//   drives the registered select, waits for the switch to confirm through
//   synchronised feedback, and enforces a minimum dwell time in each settled
//   state. Requests that cannot be served immediately are held as a single
//   pending request (last one wins).
//
//   Optional feature (macro CLKSEL_TIMEOUT_EN): a watchdog on the TO_* states.
//   If confirmation has not arrived after TIMEOUT_CYCLES cycles the sequencer
//   sets the sticky switch_err, drops hsclk_sel, returns to LS and discards
//   the pending request. Without the macro the TO_* states wait forever and
//   switch_err is constant 0.
//
//   Parameters:
//     SYNC_STAGES     synchroniser depth for the feedback inputs
//     DWELL_CYCLES    settled cycles required before the next switch
//     TIMEOUT_CYCLES  confirmation watchdog limit (CLKSEL_TIMEOUT_EN only)
//   Ports:
//     hsclk_in   in   sole clock, posedge
//     rst        in   synchronous active-high reset
//     sw         slave modport of clksel_seq_if (request/feedback/status)
//     state_dbg  out  current sequencer state (clksel_state_e encoding)
// -----------------------------------------------------------------------------
module clksel_seq
    import clkctrl_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int DWELL_CYCLES   = DWELL_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic         hsclk_in,
    input  logic         rst,
    clksel_seq_if.slave  sw,
    output logic [1:0]   state_dbg
);

    if (DWELL_CYCLES < 0) begin : g_bad_dwell
        $error("clksel_seq: DWELL_CYCLES must not be negative");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("clksel_seq: TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [1:0] ST_LS    = CLKSEL_LS;
    localparam logic [1:0] ST_TO_HS = CLKSEL_TO_HS;
    localparam logic [1:0] ST_HS    = CLKSEL_HS;
    localparam logic [1:0] ST_TO_LS = CLKSEL_TO_LS;

    localparam int            DW         = cnt_width(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES);

    // -------------------------------------------------------------------------
    // Feedback synchronisers
    // -------------------------------------------------------------------------
    logic sync_hs;
    logic sync_ls;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_hs (
        .clk (hsclk_in),
        .rst (rst),
        .d   (sw.hsclk_selected),
        .q   (sync_hs)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ls (
        .clk (hsclk_in),
        .rst (rst),
        .d   (sw.lsclk_selected),
        .q   (sync_ls)
    );

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]    state_q,     state_n;
    logic          sel_q,       sel_n;
    logic          done_q,      done_n;
    logic          pend_q,      pend_n;
    logic          pend_fast_q, pend_fast_n;
    logic [DW-1:0] dwell_q,     dwell_n;
    logic          err_q;

`ifdef CLKSEL_TIMEOUT_EN
    localparam int            TW      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          err_n;
    logic [TW-1:0] to_cnt_q, to_cnt_n;
`endif

    logic dwell_zero;
    logic cur_fast;
    logic eff_valid;
    logic eff_fast;
    logic confirm;

    assign dwell_zero = (dwell_q == '0);
    assign cur_fast   = (state_q == ST_HS);

    // A fresh strobe overrides the pending request in the same cycle.
    assign eff_valid = sw.req_valid | pend_q;
    assign eff_fast  = sw.req_valid ? sw.req_fast : pend_fast_q;

    // Both-high or both-low feedback is the break-before-make gap: no confirm.
    assign confirm = (state_q == ST_TO_HS) ? (sync_hs & ~sync_ls)
                                           : (sync_ls & ~sync_hs);

    always_comb begin
        state_n     = state_q;
        sel_n       = sel_q;
        done_n      = 1'b0;
        pend_n      = pend_q;
        pend_fast_n = pend_fast_q;
        dwell_n     = dwell_zero ? '0 : dwell_q - DW'(1);
`ifdef CLKSEL_TIMEOUT_EN
        err_n       = err_q;
        to_cnt_n    = '0;
`endif

        case (state_q)
            ST_LS, ST_HS: begin
                if (eff_valid) begin
                    if (eff_fast == cur_fast) begin
                        // Already on the requested clock: nothing to do.
                        pend_n = 1'b0;
                    end else if (dwell_zero) begin
                        state_n = eff_fast ? ST_TO_HS : ST_TO_LS;
                        sel_n   = eff_fast;
                        pend_n  = 1'b0;
                    end else begin
                        pend_n      = 1'b1;
                        pend_fast_n = eff_fast;
                    end
                end
            end

            ST_TO_HS, ST_TO_LS: begin
                // The select is frozen here; requests only update pending.
                if (sw.req_valid) begin
                    pend_n      = 1'b1;
                    pend_fast_n = sw.req_fast;
                end
                if (confirm) begin
                    state_n = (state_q == ST_TO_HS) ? ST_HS : ST_LS;
                    done_n  = 1'b1;
                    dwell_n = DWELL_LOAD;
                end
`ifdef CLKSEL_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    err_n   = 1'b1;
                    sel_n   = 1'b0;
                    state_n = ST_LS;
                    pend_n  = 1'b0;
                end else begin
                    to_cnt_n = to_cnt_q + TW'(1);
                end
`endif
            end

            default: begin
                state_n = ST_LS;
                sel_n   = 1'b0;
                pend_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            state_q     <= ST_LS;
            sel_q       <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_fast_q <= 1'b0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_n;
            sel_q       <= sel_n;
            done_q      <= done_n;
            pend_q      <= pend_n;
            pend_fast_q <= pend_fast_n;
            dwell_q     <= dwell_n;
        end
    end

`ifdef CLKSEL_TIMEOUT_EN
    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            err_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            err_q    <= err_n;
            to_cnt_q <= to_cnt_n;
        end
    end
`else
    assign err_q = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sw.hsclk_sel   = sel_q;
    assign sw.switch_done = done_q;
    assign sw.switch_err  = err_q;
    assign sw.busy        = (state_q == ST_TO_HS) | (state_q == ST_TO_LS)
                          | ~dwell_zero | pend_q;
    assign state_dbg      = state_q;

endmodule : clksel_seq

// File: tb/tb_clksel_seq.sv
// -----------------------------------------------------------------------------
// tb_clksel_seq
//   Directed bench for clksel_seq (SYNC_STAGES=2, DWELL_CYCLES=16,
//   TIMEOUT_CYCLES=8). A cycle model derived from the behavioural rules is
//   compared against the DUT every cycle; literal expectations pin key
//   moments of each scenario. Builds with or without CLKSEL_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_clksel_seq;
    import clkctrl_pkg::*;

    localparam int SYNC    = 2;
    localparam int DWELL   = 16;
    localparam int TIMEOUT = 8;
`ifdef CLKSEL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------------------------------------------------------- clock/reset
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    clksel_seq_if bus ();

    clksel_seq #(
        .SYNC_STAGES    (SYNC),
        .DWELL_CYCLES   (DWELL),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .hsclk_in  (clk),
        .rst       (rst),
        .sw        (bus),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Tracks: selected clock, whether a switch is in flight, remaining dwell,
    // the (at most one) pending request, and the feedback as seen through the
    // synchroniser delay line.
    bit m_live = 1'b0;
    bit m_sel, m_fly, m_done, m_err;
    int m_dwell, m_elapsed;
    bit m_pend[$];
    bit hs_line[$];
    bit ls_line[$];

    always @(posedge clk) begin
        bit s_hs, s_ls, have, dir, ok;
        int old_dwell;
        if (rst) begin
            m_live = 1'b1;
            m_sel = 0; m_fly = 0; m_done = 0; m_err = 0;
            m_dwell = 0; m_elapsed = 0;
            m_pend.delete();
            hs_line.delete();
            ls_line.delete();
            for (int i = 0; i < SYNC; i++) begin
                hs_line.push_back(1'b0);
                ls_line.push_back(1'b0);
            end
        end else if (m_live) begin
            s_hs = hs_line.pop_front();
            s_ls = ls_line.pop_front();
            hs_line.push_back(bus.hsclk_selected);
            ls_line.push_back(bus.lsclk_selected);
            m_done = 0;
            if (!m_fly) begin
                have = bus.req_valid || (m_pend.size() != 0);
                dir  = bus.req_valid ? bus.req_fast
                                     : ((m_pend.size() != 0) ? m_pend[0] : 1'b0);
                old_dwell = m_dwell;
                if (m_dwell > 0) m_dwell--;
                if (have) begin
                    m_pend.delete();
                    if (dir != m_sel) begin
                        if (old_dwell == 0) begin
                            m_sel = dir;
                            m_fly = 1;
                            m_elapsed = 0;
                        end else begin
                            m_pend.push_back(dir);
                        end
                    end
                end
            end else begin
                if (bus.req_valid) begin
                    m_pend.delete();
                    m_pend.push_back(bus.req_fast);
                end
                ok = m_sel ? (s_hs && !s_ls) : (s_ls && !s_hs);
                if (ok) begin
                    m_fly = 0;
                    m_done = 1;
                    m_dwell = DWELL;
                end else if (TO_EN) begin
                    m_elapsed++;
                    if (m_elapsed >= TIMEOUT) begin
                        m_err = 1;
                        m_sel = 0;
                        m_fly = 0;
                        m_pend.delete();
                    end
                end
            end
        end
    end

    function automatic logic [1:0] m_state();
        if (m_fly) return m_sel ? CLKSEL_TO_HS : CLKSEL_TO_LS;
        return m_sel ? CLKSEL_HS : CLKSEL_LS;
    endfunction

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_sel",   bus.hsclk_sel,   m_sel);
            check("cyc_busy",  bus.busy,        (m_fly || m_dwell > 0 || m_pend.size() != 0));
            check("cyc_done",  bus.switch_done, m_done);
            check("cyc_err",   bus.switch_err,  m_err);
            check("cyc_state", state_dbg,       m_state());
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_req(input logic fast);
        bus.req_valid = 1'b1;
        bus.req_fast  = fast;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic set_fb(input logic hs, input logic ls);
        bus.hsclk_selected = hs;
        bus.lsclk_selected = ls;
    endtask

    // ---------------------------------------------------------------- scenarios
    initial begin
        int ndone;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_fast  = 1'b0;
        set_fb(1'b0, 1'b1);
        repeat (3) step();
        check("rst_sel",   bus.hsclk_sel,   1'b0);
        check("rst_busy",  bus.busy,        1'b0);
        check("rst_done",  bus.switch_done, 1'b0);
        check("rst_err",   bus.switch_err,  1'b0);
        check("rst_state", state_dbg,       CLKSEL_LS);
        rst = 1'b0;
        step();

        // Same-direction request in LS is ignored.
        pulse_req(1'b0);
        check("ign_sel",  bus.hsclk_sel, 1'b0);
        check("ign_busy", bus.busy,      1'b0);
        repeat (2) step();

        // LS -> HS: one-cycle select latency, done 2+1 cycles after feedback.
        pulse_req(1'b1);
        check("lat_sel",   bus.hsclk_sel, 1'b1);
        check("lat_state", state_dbg,     CLKSEL_TO_HS);
        set_fb(1'b1, 1'b0);
        step();
        step();
        check("done_early", bus.switch_done, 1'b0);
        step();
        check("done_hs",    bus.switch_done, 1'b1);
        check("state_hs",   state_dbg,       CLKSEL_HS);

        // Request LS at cycle 5 of dwell; select drops at cycle 17.
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c == 5) begin
                bus.req_valid = 1'b1;
                bus.req_fast  = 1'b0;
            end
            if (c == 6) bus.req_valid = 1'b0;
            if (c == 10) check("dwell_busy", bus.busy, 1'b1);
            if (c == 16) begin
                check("dwell_hold_sel", bus.hsclk_sel, 1'b1);
                check("pend_busy",      bus.busy,      1'b1);
            end
            if (c == 17) begin
                check("dwell_drop_sel", bus.hsclk_sel, 1'b0);
                check("dwell_to_ls",    state_dbg,     CLKSEL_TO_LS);
            end
        end
        set_fb(1'b0, 1'b1);
        step();
        step();
        check("done_ls_early", bus.switch_done, 1'b0);
        step();
        check("done_ls",  bus.switch_done, 1'b1);
        check("state_ls", state_dbg,       CLKSEL_LS);
        repeat (20) step();
        check("dwell_exp_busy", bus.busy, 1'b0);

        // Reset in the middle of TO_HS.
        pulse_req(1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        check("mid_rst_sel",   bus.hsclk_sel,   1'b0);
        check("mid_rst_busy",  bus.busy,        1'b0);
        check("mid_rst_done",  bus.switch_done, 1'b0);
        check("mid_rst_err",   bus.switch_err,  1'b0);
        check("mid_rst_state", state_dbg,       CLKSEL_LS);
        rst = 1'b0;
        step();

        // During TO_HS: LS then HS requests; HS pending is discarded in HS.
        pulse_req(1'b1);
        step();
        pulse_req(1'b0);
        check("pend_sel_frozen", bus.hsclk_sel, 1'b1);
        check("pend_state",      state_dbg,     CLKSEL_TO_HS);
        pulse_req(1'b1);
        set_fb(1'b1, 1'b0);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.switch_done === 1'b1) ndone++;
        end
        check("pend_one_done", ndone,         1);
        check("pend_end_busy", bus.busy,      1'b0);
        check("pend_end_sel",  bus.hsclk_sel, 1'b1);
        check("pend_end_st",   state_dbg,     CLKSEL_HS);

        // HS -> LS with both feedback inputs high for 10 cycles.
        pulse_req(1'b0);
        check("bb_sel",   bus.hsclk_sel, 1'b0);
        check("bb_state", state_dbg,     CLKSEL_TO_LS);
        set_fb(1'b1, 1'b1);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.switch_done === 1'b1) ndone++;
        end
        check("bb_no_done", ndone, 0);
`ifdef CLKSEL_TIMEOUT_EN
        check("bb_to_state", state_dbg,      CLKSEL_LS);
        check("bb_to_err",   bus.switch_err, 1'b1);
`else
        check("bb_hold_state", state_dbg,      CLKSEL_TO_LS);
        check("bb_hold_err",   bus.switch_err, 1'b0);
`endif
        set_fb(1'b0, 1'b1);
        repeat (3) step();
`ifdef CLKSEL_TIMEOUT_EN
        check("bb_late_done", bus.switch_done, 1'b0);
`else
        check("bb_late_done", bus.switch_done, 1'b1);
        check("bb_late_st",   state_dbg,       CLKSEL_LS);
`endif

        // Feedback stuck low in TO_HS: watchdog (when built in) at cycle 8.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        pulse_req(1'b1);
        set_fb(1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 7) begin
                check("to_k7_err", bus.switch_err, 1'b0);
                check("to_k7_sel", bus.hsclk_sel,  1'b1);
            end
            if (k == 8) begin
`ifdef CLKSEL_TIMEOUT_EN
                check("to_k8_err",   bus.switch_err, 1'b1);
                check("to_k8_sel",   bus.hsclk_sel,  1'b0);
                check("to_k8_state", state_dbg,      CLKSEL_LS);
                check("to_k8_busy",  bus.busy,       1'b0);
`else
                check("to_k8_err",   bus.switch_err, 1'b0);
                check("to_k8_sel",   bus.hsclk_sel,  1'b1);
                check("to_k8_state", state_dbg,      CLKSEL_TO_HS);
                check("to_k8_busy",  bus.busy,       1'b1);
`endif
            end
        end
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clksel_seq

// File: doc/clksel_seq.md
CLKSEL_SEQ -- requirements
Module: clksel_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for the hsclk_selected/lsclk_selected feedback.
REQ-002 SHALL have parameter DWELL_CYCLES, default 16, the minimum number of hsclk_in cycles spent in a settled state before another switch may start.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum wait for switch confirmation; used only with CLKSEL_TIMEOUT_EN.
REQ-004 hsclk_in  in  1  sole clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  one-cycle strobe presenting a clock request.
REQ-007 req_fast  in  1  requested clock, sampled with req_valid: 1 = HS, 0 = LS.
REQ-008 hsclk_selected  in  1  asynchronous feedback from the clock switch.
REQ-009 lsclk_selected  in  1  asynchronous feedback from the clock switch.
REQ-010 hsclk_sel  out  1  registered select driven to the clock switch.
REQ-011 busy  out  1  high while a switch is in flight or dwell is pending.
REQ-012 switch_done  out  1  one-cycle pulse when a switch is confirmed.
REQ-013 switch_err  out  1  sticky timeout flag; cleared only by rst.

Function
REQ-014 SHALL pass both feedback inputs through SYNC_STAGES flops before any use; the synchronised values are sync_hs and sync_ls.
REQ-015 SHALL implement the states LS, TO_HS, HS and TO_LS.
REQ-016 LS: on req_valid&req_fast with the dwell counter expired, SHALL assert hsclk_sel on the next edge and enter TO_HS; any other request SHALL be ignored.
REQ-017 TO_HS: when sync_hs=1 and sync_ls=0, SHALL enter HS, pulse switch_done and load the dwell counter with DWELL_CYCLES.
REQ-018 HS: on req_valid&!req_fast with the dwell counter expired, SHALL deassert hsclk_sel and enter TO_LS.
REQ-019 TO_LS: when sync_ls=1 and sync_hs=0, SHALL enter LS, pulse switch_done and reload the dwell counter.
REQ-020 A request arriving during TO_*, or before dwell has expired, SHALL be latched as a single pending bit plus its direction; a later request SHALL overwrite it (last wins).
REQ-021 The pending request SHALL be acted on in the first cycle it becomes legal.
REQ-022 A pending request equal to the current settled state SHALL be discarded without a transition.
REQ-023 busy SHALL equal (state is TO_*) | (dwell counter nonzero) | (pending bit set).
REQ-024 The dwell counter SHALL saturate at 0 and SHALL NOT wrap.
REQ-025 Latency from req_valid to a hsclk_sel change SHALL be exactly 1 cycle when legal.
REQ-026 Feedback showing both selected or neither selected during TO_* is a legal break-before-make interval and SHALL hold the state.
REQ-027 hsclk_sel SHALL never toggle while in TO_HS or TO_LS.

Reset
REQ-028 rst SHALL put the block in state LS, with hsclk_sel=0, busy=0, switch_done=0, switch_err=0, pending cleared, dwell counter=0 and synchroniser flops=0.
REQ-029 rst asserted mid-switch SHALL abort the switch and drop hsclk_sel in the same cycle.

Configuration
REQ-030 With CLKSEL_TIMEOUT_EN defined, a counter SHALL run in TO_* states; reaching TIMEOUT_CYCLES SHALL set switch_err, force hsclk_sel=0, enter LS and clear pending.
REQ-031 Without CLKSEL_TIMEOUT_EN, no timeout counter SHALL exist, switch_err SHALL be tied to 0, and TO_* states SHALL wait indefinitely.

Structure
REQ-032 The state encoding enum and default parameter constants SHALL live in the shared package clkctrl_pkg.
REQ-033 The feedback synchroniser SHALL be a sub-module sync_ff (parameterised depth), instantiated twice.

Verification
REQ-034 Reset, then req_valid/req_fast=1 -> hsclk_sel=1 one cycle later; after hsclk_selected=1 and lsclk_selected=0 -> switch_done pulse 2+1 cycles later, state HS.
REQ-035 In HS with dwell=16, request LS at cycle 5 -> busy held, hsclk_sel drops at cycle 16+1, not earlier.
REQ-036 During TO_HS, send LS then HS requests -> pending resolves to HS, which is discarded on arrival in HS, and no extra transition occurs.
REQ-037 With CLKSEL_TIMEOUT_EN and TIMEOUT_CYCLES=8, feedback stuck low -> switch_err=1 at cycle 8, hsclk_sel=0, state LS.
REQ-038 rst pulsed during TO_HS -> next cycle all outputs at their reset values.
REQ-039 Both feedback inputs held at 1 for 10 cycles in TO_LS -> state held, no switch_done pulse.
